// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: start/data/stop deserialiser with glitch reject and framing-error/break handling.
// Optional rx input synchroniser enabled by defining UART_RX_SYNC_EN.
module uart_rx #(
    parameter int D_WIDTH      = 10,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx,
    output logic [D_WIDTH-1:0] rx_data,
    output logic               rx_valid,
    output logic               rx_err,
    output logic               rx_busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int HALF  = (CLKS_PER_BIT - 1) / 2;
    localparam int BIT_W = $clog2(D_WIDTH + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(D_WIDTH - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [BIT_W-1:0]   bit_idx;
    logic [D_WIDTH-1:0] shift;
    logic               rx_s;

`ifdef UART_RX_SYNC_EN
    // Two-flop synchroniser; resets to the idle line level so reset never fakes a start bit.
    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end

    assign rx_s = sync_q[1];
`else
    assign rx_s = rx;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            rx_busy  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (!rx_s) begin
                        rx_busy <= 1'b1;
                        // With a zero half-bit offset this detection already is the mid-bit re-check.
                        if (HALF == 0) begin
                            state <= DATA;
                        end else begin
                            state <= START;
                            cnt   <= CNT_ONE;
                        end
                    end
                end
                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state   <= IDLE;
                            rx_busy <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt     <= '0;
                        shift   <= {rx_s, shift[D_WIDTH-1:1]};
                        bit_idx <= bit_idx + BIT_ONE;
                        if (bit_idx == BIT_LAST) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            rx_data  <= shift;
                            rx_valid <= 1'b1;
                            rx_busy  <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            rx_err <= 1'b1;
                            state  <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                BREAK: begin
                    // A line stuck low after a bad stop bit must go idle before another frame can start.
                    if (rx_s) begin
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
